conv_window_feeder: RTL

Front-end sequencer that drives the 3x3 convolution core. Accepts a serial stream of signed words (nine kernel weights, then a raster-order image), builds 3x3 windows with two line buffers, and presents them to the core on parallel buses with one-cycle `w_w` / `if_w` write strobes. Sits between the pixel source (memory reader or testbench) and the CONV datapath. No padding: windows are emitted only where fully inside the image.

---
 rtl/conv_window_feeder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_feeder.sv
// Streams nine kernel weights then a raster-order image, and presents each fully-inside
// 3x3 window to the convolution core with one-cycle write strobes.
module conv_window_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       in_ready,
  output logic signed [DATA_W-1:0]   w_out0,
  output logic signed [DATA_W-1:0]   w_out1,
  output logic signed [DATA_W-1:0]   w_out2,
  output logic signed [DATA_W-1:0]   w_out3,
  output logic signed [DATA_W-1:0]   w_out4,
  output logic signed [DATA_W-1:0]   w_out5,
  output logic signed [DATA_W-1:0]   w_out6,
  output logic signed [DATA_W-1:0]   w_out7,
  output logic signed [DATA_W-1:0]   w_out8,
  output logic                       w_w,
  output logic signed [DATA_W-1:0]   if_out0,
  output logic signed [DATA_W-1:0]   if_out1,
  output logic signed [DATA_W-1:0]   if_out2,
  output logic signed [DATA_W-1:0]   if_out3,
  output logic signed [DATA_W-1:0]   if_out4,
  output logic signed [DATA_W-1:0]   if_out5,
  output logic signed [DATA_W-1:0]   if_out6,
  output logic signed [DATA_W-1:0]   if_out7,
  output logic signed [DATA_W-1:0]   if_out8,
  output logic                       if_w,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_IF} state_t;

  state_t                    state_q;
  logic [3:0]                wcnt_q;
  logic [RW-1:0]             row_q;
  logic [CW-1:0]             col_q;
  logic signed [DATA_W-1:0]  w_q   [9];
  logic signed [DATA_W-1:0]  win_q [9];
  logic                      in_ready_q;
  logic                      busy_q;
  logic                      w_w_q;
  logic                      if_w_q;
  logic                      done_q;
  logic [RW-1:0]             win_row_q;
  logic [CW-1:0]             win_col_q;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column.
  logic signed [DATA_W-1:0]  lb1_q [IMG_W];
  logic signed [DATA_W-1:0]  lb2_q [IMG_W];

  logic                      accept;
  logic                      last_col;
  logic                      last_row;
  logic                      win_valid;
  logic signed [DATA_W-1:0]  up1_px;
  logic signed [DATA_W-1:0]  up2_px;
  logic [RW-1:0]             row_d;
  logic [CW-1:0]             col_d;

  assign accept    = in_valid & in_ready_q;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));
  assign win_valid = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign up1_px    = lb1_q[col_q];
  assign up2_px    = lb2_q[col_q];

  always_comb begin
    col_d = col_q + CW'(1);
    row_d = row_q;
    if (last_col) begin
      col_d = '0;
      row_d = row_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      w_w_q      <= 1'b0;
      if_w_q     <= 1'b0;
      done_q     <= 1'b0;
      win_row_q  <= '0;
      win_col_q  <= '0;
      for (int k = 0; k < 9; k++) begin
        w_q[k]   <= '0;
        win_q[k] <= '0;
      end
    end else begin
      w_w_q  <= 1'b0;
      if_w_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD_W;
            wcnt_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD_W: begin
          if (accept) begin
            w_q[wcnt_q] <= in_data;
            if (wcnt_q == 4'd8) begin
              w_w_q   <= 1'b1;
              state_q <= LOAD_IF;
              wcnt_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end
        end
        LOAD_IF: begin
          if (accept) begin
            // Shift window left; right column comes from the line buffers and the new pixel.
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= up2_px;
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[5] <= up1_px;
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
            win_q[8] <= in_data;
            row_q    <= row_d;
            col_q    <= col_d;
            if (win_valid) begin
              if_w_q    <= 1'b1;
              win_row_q <= row_q - RW'(1);
              win_col_q <= col_q - CW'(1);
            end
            if (last_col && last_row) begin
              done_q     <= 1'b1;
              state_q    <= IDLE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Storage only; a fresh frame rewrites rows 0 and 1 before any strobed window reads them.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_IF && accept) begin
      lb1_q[col_q] <= in_data;
      lb2_q[col_q] <= up1_px;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign w_w      = w_w_q;
  assign if_w     = if_w_q;
  assign done     = done_q;
  assign win_row  = win_row_q;
  assign win_col  = win_col_q;

  assign w_out0 = w_q[0];
  assign w_out1 = w_q[1];
  assign w_out2 = w_q[2];
  assign w_out3 = w_q[3];
  assign w_out4 = w_q[4];
  assign w_out5 = w_q[5];
  assign w_out6 = w_q[6];
  assign w_out7 = w_q[7];
  assign w_out8 = w_q[8];

  assign if_out0 = win_q[0];
  assign if_out1 = win_q[1];
  assign if_out2 = win_q[2];
  assign if_out3 = win_q[3];
  assign if_out4 = win_q[4];
  assign if_out5 = win_q[5];
  assign if_out6 = win_q[6];
  assign if_out7 = win_q[7];
  assign if_out8 = win_q[8];

endmodule
